// File: rtl/mem_write_checker_if.sv
// Data-memory store port of the core, as seen by the store-stream checker.
//   mem_write   store strobe, one store per cycle while high
//   data_adr    store address
//   write_data  store data
// Modports:
//   master  the core (or a bench) driving the store port
//   slave   an observer such as mem_write_checker
interface mem_write_checker_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker.sv
// Store-stream checker for processor bring-up.
// Watches the core's data-memory write port and matches stores against a
// programmable list of expected (address, data) pairs. Stores to scratch
// addresses are skipped. The verdict (pass, fail or timeout) is held on
// sticky status outputs until the next start.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      1-cycle pulse: clear and arm (ignored while busy)
//   bus        store port (mem_write / data_adr / write_data), slave side
//   exp_adr    expected addresses, entry i at [i*ADDR_W +: ADDR_W]
//   exp_data   expected data, same packing
//   ign_adr    scratch addresses to skip, same packing
//   busy       checker is running
//   done       verdict reached (pass | fail), sticky
//   pass       every expected store seen, sticky
//   fail       wrong/unexpected store or timeout, sticky
//   timed_out  the failure was a timeout
//   match_cnt  expected entries matched so far
//   cycle_cnt  cycles spent running (saturates at TIMEOUT)
//   err_adr    address of the offending store (0 on timeout)
//   err_data   data of the offending store (0 on timeout)
module mem_write_checker #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_EXP = 4,
  parameter int unsigned NUM_IGN = 2,
  parameter int unsigned ORDERED = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  mem_write_checker_if.slave                              bus,
  input  logic [NUM_EXP*ADDR_W-1:0]                       exp_adr,
  input  logic [NUM_EXP*DATA_W-1:0]                       exp_data,
  input  logic [((NUM_IGN > 0) ? NUM_IGN : 1)*ADDR_W-1:0] ign_adr,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            pass,
  output logic                                            fail,
  output logic                                            timed_out,
  output logic [4:0]                                      match_cnt,
  output logic [$clog2(TIMEOUT+1)-1:0]                    cycle_cnt,
  output logic [ADDR_W-1:0]                               err_adr,
  output logic [DATA_W-1:0]                               err_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASSED,
    FAILED
  } state_t;

  state_t             state;
  logic [NUM_EXP-1:0] hitMap;     // entries already consumed (unordered mode)
  logic [NUM_EXP-1:0] entryEq;    // current store equals entry i
  logic [NUM_EXP-1:0] matchOh;    // entry consumed by the current store
  logic               isMatch;
  logic               isIgnored;
  logic               lastMatch;
  logic               storeMatch;
  logic               storeFail;
  logic               timeoutHit;
  logic [CNT_W-1:0]   cycleNext;

  // Full-width exact compare of the store against every expected entry.
  always_comb begin
    entryEq = '0;
    for (int unsigned i = 0; i < NUM_EXP; i++) begin
      entryEq[i] = (bus.data_adr   == exp_adr[i*ADDR_W +: ADDR_W]) &&
                   (bus.write_data == exp_data[i*DATA_W +: DATA_W]);
    end
  end

  // Ordered: only the entry at match_cnt may match.
  // Unordered: the lowest not-yet-hit equal entry wins, so a repeat of an
  // already-hit entry finds no candidate and falls through to fail.
  always_comb begin
    matchOh = '0;
    isMatch = 1'b0;
    for (int unsigned i = 0; i < NUM_EXP; i++) begin
      if (ORDERED != 0) begin
        if ((32'(match_cnt) == i) && entryEq[i]) begin
          matchOh[i] = 1'b1;
          isMatch    = 1'b1;
        end
      end else if (!isMatch && entryEq[i] && !hitMap[i]) begin
        matchOh[i] = 1'b1;
        isMatch    = 1'b1;
      end
    end
  end

  always_comb begin
    isIgnored = 1'b0;
    for (int unsigned i = 0; i < NUM_IGN; i++) begin
      if (bus.data_adr == ign_adr[i*ADDR_W +: ADDR_W]) begin
        isIgnored = 1'b1;
      end
    end
  end

  // Match takes priority over the scratch list, which takes priority over fail.
  assign storeMatch = bus.mem_write && isMatch;
  assign lastMatch  = storeMatch && (match_cnt == 5'(NUM_EXP - 1));
  assign storeFail  = bus.mem_write && !isMatch && !isIgnored;

  assign cycleNext  = (cycle_cnt == CNT_W'(TIMEOUT)) ? cycle_cnt
                                                     : cycle_cnt + CNT_W'(1);
  // Timeout is only taken when the store on the same edge did not settle the
  // verdict; a store on the terminal cycle wins.
  assign timeoutHit = (cycleNext == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      err_adr   <= '0;
      err_data  <= '0;
      hitMap    <= '0;
    end else begin
      case (state)
        IDLE, PASSED, FAILED: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timed_out <= 1'b0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            err_adr   <= '0;
            err_data  <= '0;
            hitMap    <= '0;
          end
        end

        RUN: begin
          cycle_cnt <= cycleNext;
          if (storeMatch) begin
            match_cnt <= match_cnt + 5'd1;
            hitMap    <= hitMap | matchOh;
          end
          if (lastMatch) begin
            state <= PASSED;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (storeFail) begin
            state    <= FAILED;
            busy     <= 1'b0;
            done     <= 1'b1;
            fail     <= 1'b1;
            err_adr  <= bus.data_adr;
            err_data <= bus.write_data;
          end else if (timeoutHit) begin
            state     <= FAILED;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            timed_out <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker. Three checkers share one store bus:
//   A: one expected store {100,7}, scratch {96}, ordered, timeout 20
//   B: {(4,1),(8,2)}, scratch {96,200}, ordered, timeout 20
//   C: {(4,1),(8,2)}, scratch {96}, unordered, timeout 25
// A list-based model tracks each checker's verdict; a compare process checks
// every output on every falling edge, and directed steps pin hand-derived values.
module tb_mem_write_checker;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  logic        busyA, doneA, passA, failA, tmoA;
  logic [4:0]  mcA, cycA;
  logic [31:0] eaA, edA;
  logic        busyB, doneB, passB, failB, tmoB;
  logic [4:0]  mcB, cycB;
  logic [31:0] eaB, edB;
  logic        busyC, doneC, passC, failC, tmoC;
  logic [4:0]  mcC, cycC;
  logic [31:0] eaC, edC;

  logic [31:0] expAdrA  = 32'd100;
  logic [31:0] expDataA = 32'd7;
  logic [31:0] ignA     = 32'd96;
  logic [63:0] expAdrBC  = {32'd8, 32'd4};
  logic [63:0] expDataBC = {32'd2, 32'd1};
  logic [63:0] ignB      = {32'd200, 32'd96};
  logic [31:0] ignC      = 32'd96;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .NUM_IGN(1), .ORDERED(1), .TIMEOUT(20)
  ) dutA (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .exp_adr(expAdrA), .exp_data(expDataA), .ign_adr(ignA),
    .busy(busyA), .done(doneA), .pass(passA), .fail(failA), .timed_out(tmoA),
    .match_cnt(mcA), .cycle_cnt(cycA), .err_adr(eaA), .err_data(edA)
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .NUM_IGN(2), .ORDERED(1), .TIMEOUT(20)
  ) dutB (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .exp_adr(expAdrBC), .exp_data(expDataBC), .ign_adr(ignB),
    .busy(busyB), .done(doneB), .pass(passB), .fail(failB), .timed_out(tmoB),
    .match_cnt(mcB), .cycle_cnt(cycB), .err_adr(eaB), .err_data(edB)
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .NUM_IGN(1), .ORDERED(0), .TIMEOUT(25)
  ) dutC (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .exp_adr(expAdrBC), .exp_data(expDataBC), .ign_adr(ignC),
    .busy(busyC), .done(doneC), .pass(passC), .fail(failC), .timed_out(tmoC),
    .match_cnt(mcC), .cycle_cnt(cycC), .err_adr(eaC), .err_data(edC)
  );

  int nVec = 0;
  int nMis = 0;

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  int    cfgTimeout[3] = '{20, 20, 25};
  bit    cfgOrdered[3] = '{1'b1, 1'b1, 1'b0};
  pair_t rem[3][$];       // expected stores still outstanding
  bit    mRun[3], mPass[3], mFail[3], mTmo[3];
  int    mMatch[3], mCyc[3];
  bit [31:0] mErrA[3], mErrD[3];

  function automatic bit ignoredBy(int k, logic [31:0] a);
    case (k)
      1:       return (a == 32'd96) || (a == 32'd200);
      default: return (a == 32'd96);
    endcase
  endfunction

  task automatic modelClear(int k);
    mRun[k] = 0; mPass[k] = 0; mFail[k] = 0; mTmo[k] = 0;
    mMatch[k] = 0; mCyc[k] = 0; mErrA[k] = '0; mErrD[k] = '0;
    rem[k].delete();
  endtask

  task automatic modelStep(int k, bit st, bit w, logic [31:0] a, logic [31:0] d);
    int pos;
    bit settled;
    if (!mRun[k]) begin
      if (st) begin
        modelClear(k);
        mRun[k] = 1;
        if (k == 0) begin
          rem[k].push_back(pair_t'{32'd100, 32'd7});
        end else begin
          rem[k].push_back(pair_t'{32'd4, 32'd1});
          rem[k].push_back(pair_t'{32'd8, 32'd2});
        end
      end
      return;
    end
    if (mCyc[k] < cfgTimeout[k]) mCyc[k]++;
    settled = 0;
    if (w) begin
      pos = -1;
      if (cfgOrdered[k]) begin
        if (rem[k].size() > 0 && rem[k][0].a == a && rem[k][0].d == d) pos = 0;
      end else begin
        for (int j = 0; j < rem[k].size(); j++)
          if (pos < 0 && rem[k][j].a == a && rem[k][j].d == d) pos = j;
      end
      if (pos >= 0) begin
        rem[k].delete(pos);
        mMatch[k]++;
        if (rem[k].size() == 0) begin
          mRun[k] = 0; mPass[k] = 1; settled = 1;
        end
      end else if (!ignoredBy(k, a)) begin
        mRun[k] = 0; mFail[k] = 1; mErrA[k] = a; mErrD[k] = d; settled = 1;
      end
    end
    if (!settled && mCyc[k] == cfgTimeout[k]) begin
      mRun[k] = 0; mFail[k] = 1; mTmo[k] = 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) modelClear(k);
    end else begin
      for (int k = 0; k < 3; k++)
        modelStep(k, start, bus.mem_write, bus.data_adr, bus.write_data);
    end
  end

  task automatic cmpInst(int k, logic b, logic dn, logic p, logic f, logic t,
                         logic [4:0] mc, logic [4:0] cy, logic [31:0] ea, logic [31:0] ed);
    chk("busy", k, 64'(b), 64'(mRun[k]));
    chk("done", k, 64'(dn), 64'(mPass[k] | mFail[k]));
    chk("pass", k, 64'(p), 64'(mPass[k]));
    chk("fail", k, 64'(f), 64'(mFail[k]));
    chk("timed_out", k, 64'(t), 64'(mTmo[k]));
    chk("match_cnt", k, 64'(mc), 64'(mMatch[k]));
    chk("cycle_cnt", k, 64'(cy), 64'(mCyc[k]));
    chk("err_adr", k, 64'(ea), 64'(mErrA[k]));
    chk("err_data", k, 64'(ed), 64'(mErrD[k]));
  endtask

  always @(negedge clk) begin
    cmpInst(0, busyA, doneA, passA, failA, tmoA, mcA, cycA, eaA, edA);
    cmpInst(1, busyB, doneB, passB, failB, tmoB, mcB, cycB, eaB, edB);
    cmpInst(2, busyC, doneC, passC, failC, tmoC, mcC, cycC, eaC, edC);
  end

  // ---------------- directed stimulus ----------------
  // Called on a falling edge; applies inputs across one rising edge.
  task automatic tick(bit s, bit w, logic [31:0] a, logic [31:0] d);
    start = s;
    bus.mem_write = w;
    bus.data_adr = a;
    bus.write_data = d;
    @(negedge clk);
    start = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_adr = '0;
    bus.write_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, 64'(busyA), 64'd0);
    chk("rst_done", 1, 64'(doneB), 64'd0);
    chk("rst_match_cnt", 2, 64'(mcC), 64'd0);
    reset = 1'b1;

    // store while idle is ignored
    tick(0, 1, 100, 7);
    chk("idle_pass", 0, 64'(passA), 64'd0);
    chk("idle_busy", 0, 64'(busyA), 64'd0);

    // scratch store then the expected store
    tick(1, 0, 0, 0);
    chk("arm_busy", 0, 64'(busyA), 64'd1);
    chk("arm_cycle", 0, 64'(cycA), 64'd0);
    tick(0, 1, 96, 5);
    chk("ign_pass", 0, 64'(passA), 64'd0);
    tick(0, 1, 100, 7);
    chk("t1_pass", 0, 64'(passA), 64'd1);
    chk("t1_match_cnt", 0, 64'(mcA), 64'd1);
    chk("t1_fail", 0, 64'(failA), 64'd0);
    chk("t1_cycle", 0, 64'(cycA), 64'd2);
    chk("t1_fail", 1, 64'(failB), 64'd1);
    chk("t1_err_adr", 1, 64'(eaB), 64'd100);
    chk("t1_err_data", 1, 64'(edB), 64'd7);
    tick(0, 0, 0, 0);
    chk("t1_sticky_pass", 0, 64'(passA), 64'd1);

    // right address, wrong data
    tick(1, 0, 0, 0);
    tick(0, 1, 100, 6);
    chk("t2_fail", 0, 64'(failA), 64'd1);
    chk("t2_err_adr", 0, 64'(eaA), 64'd100);
    chk("t2_err_data", 0, 64'(edA), 64'd6);
    chk("t2_timed_out", 0, 64'(tmoA), 64'd0);

    // out-of-order stores
    tick(1, 0, 0, 0);
    tick(0, 1, 8, 2);
    chk("t3_fail", 1, 64'(failB), 64'd1);
    chk("t3_err_adr", 1, 64'(eaB), 64'd8);
    chk("t3_match_cnt", 2, 64'(mcC), 64'd1);
    tick(0, 1, 4, 1);
    chk("t3_pass", 2, 64'(passC), 64'd1);
    chk("t3_match_cnt2", 2, 64'(mcC), 64'd2);

    // in-order stores with a scratch store between
    tick(1, 0, 0, 0);
    tick(0, 1, 4, 1);
    tick(0, 1, 200, 3);
    tick(0, 1, 8, 2);
    chk("ord_pass", 1, 64'(passB), 64'd1);
    chk("ord_match_cnt", 1, 64'(mcB), 64'd2);
    chk("ord_err_adr", 2, 64'(eaC), 64'd200);

    // repeated matching store
    tick(1, 0, 0, 0);
    tick(0, 1, 4, 1);
    tick(0, 1, 4, 1);
    chk("t6_fail", 2, 64'(failC), 64'd1);
    chk("t6_err_adr", 2, 64'(eaC), 64'd4);
    chk("t6_err_data", 2, 64'(edC), 64'd1);
    chk("t6_match_cnt", 2, 64'(mcC), 64'd1);

    // timeout with no stores
    tick(1, 0, 0, 0);
    repeat (19) tick(0, 0, 0, 0);
    chk("t4_busy19", 0, 64'(busyA), 64'd1);
    chk("t4_cycle19", 0, 64'(cycA), 64'd19);
    tick(0, 0, 0, 0);
    chk("t4_fail", 0, 64'(failA), 64'd1);
    chk("t4_timed_out", 0, 64'(tmoA), 64'd1);
    chk("t4_cycle", 0, 64'(cycA), 64'd20);
    chk("t4_err_adr", 0, 64'(eaA), 64'd0);
    chk("t4_err_data", 0, 64'(edA), 64'd0);
    chk("t4_busyC", 2, 64'(busyC), 64'd1);
    repeat (5) tick(0, 0, 0, 0);
    chk("t4_timed_outC", 2, 64'(tmoC), 64'd1);
    chk("t4_cycleC", 2, 64'(cycC), 64'd25);

    // store on the terminal cycle wins over timeout
    tick(1, 0, 0, 0);
    repeat (19) tick(0, 0, 0, 0);
    tick(0, 1, 100, 7);
    chk("t4b_pass", 0, 64'(passA), 64'd1);
    chk("t4b_timed_out", 0, 64'(tmoA), 64'd0);
    chk("t4b_cycle", 0, 64'(cycA), 64'd20);
    chk("t4b_timed_outB", 1, 64'(tmoB), 64'd0);
    chk("t4b_err_adrB", 1, 64'(eaB), 64'd100);

    // start while busy, then asynchronous reset mid-run
    tick(1, 0, 0, 0);
    tick(0, 1, 4, 1);
    tick(1, 0, 0, 0);
    chk("t5_busy", 1, 64'(busyB), 64'd1);
    chk("t5_match_cnt", 1, 64'(mcB), 64'd1);
    chk("t5_cycle", 1, 64'(cycB), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_busy", 1, 64'(busyB), 64'd0);
    chk("t5_rst_match_cnt", 1, 64'(mcB), 64'd0);
    chk("t5_rst_cycle", 1, 64'(cycB), 64'd0);
    chk("t5_rst_match_cntC", 2, 64'(mcC), 64'd0);
    chk("t5_rst_busyA", 0, 64'(busyA), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1, 0, 0, 0);
    tick(0, 1, 4, 1);
    tick(0, 1, 8, 2);
    chk("t5_rearm_pass", 1, 64'(passB), 64'd1);
    chk("t5_rearm_match_cnt", 1, 64'(mcB), 64'd2);
    chk("t5_rearm_passC", 2, 64'(passC), 64'd1);
    tick(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
